// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: hard-priority video fetch reads interleaved with
// four-phase CPU reads/writes onto one synchronous RAM.
module vram_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              I_clock,
   input  logic              I_reset,
   input  logic              I_vid_rden,
   input  logic [ADDR_W-1:0] I_vid_addr,
   output logic [DATA_W-1:0] O_vid_data,
   input  logic              I_cpu_req,
   input  logic              I_cpu_we,
   input  logic [ADDR_W-1:0] I_cpu_addr,
   input  logic [DATA_W-1:0] I_cpu_wdata,
   output logic              O_cpu_ack,
   output logic [DATA_W-1:0] O_cpu_rdata,
   output logic [ADDR_W-1:0] O_ram_addr,
   output logic              O_ram_wren,
   output logic [DATA_W-1:0] O_ram_wdata,
   input  logic [DATA_W-1:0] I_ram_rdata
);

   typedef enum logic [1:0] {StIdle, StVidWait, StCpuWait} state_e;

   state_e              state_q, state_d;
   logic                rden_last_q, rden_last_d;
   logic                vid_pend_q, vid_pend_d;
   logic [DATA_W-1:0]   vid_data_q, vid_data_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic                ram_wren_q, ram_wren_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic                vid_edge;

   assign vid_edge = I_vid_rden & ~rden_last_q;

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state_q     <= StIdle;
         rden_last_q <= 1'b0;
         vid_pend_q  <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ram_addr_q  <= '0;
         ram_wren_q  <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rden_last_q <= rden_last_d;
         vid_pend_q  <= vid_pend_d;
         vid_data_q  <= vid_data_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wren_q  <= ram_wren_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rden_last_d = I_vid_rden;
      vid_pend_d  = vid_pend_q;
      vid_data_d  = vid_data_q;
      cpu_ack_d   = cpu_ack_q;
      cpu_rdata_d = cpu_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_wren_d  = ram_wren_q;
      ram_wdata_d = ram_wdata_q;

      if (!I_cpu_req) begin
         cpu_ack_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (vid_edge || vid_pend_q) begin
               ram_addr_d = I_vid_addr;
               ram_wren_d = 1'b0;
               vid_pend_d = 1'b0;
               state_d    = StVidWait;
            end else if (I_cpu_req && !cpu_ack_q) begin
               ram_addr_d  = I_cpu_addr;
               ram_wdata_d = I_cpu_wdata;
               ram_wren_d  = I_cpu_we;
               state_d     = StCpuWait;
            end else begin
               ram_wren_d = 1'b0;
            end
         end
         StVidWait: begin
            vid_data_d = I_ram_rdata;
            if (vid_edge) begin
               vid_pend_d = 1'b1;
            end
            state_d = StIdle;
         end
         StCpuWait: begin
            ram_wren_d = 1'b0;
            // wren still holds the accepted direction during this cycle
            if (!ram_wren_q) begin
               cpu_rdata_d = I_ram_rdata;
            end
            cpu_ack_d = 1'b1;
            if (vid_edge) begin
               vid_pend_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign O_vid_data  = vid_data_q;
   assign O_cpu_ack   = cpu_ack_q;
   assign O_cpu_rdata = cpu_rdata_q;
   assign O_ram_addr  = ram_addr_q;
   assign O_ram_wren  = ram_wren_q;
   assign O_ram_wdata = ram_wdata_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter sitting directly upstream of the video timing/fetch stage. It serves the fetch stage's tile-index and tile-pattern reads, which are hard-deadline and top priority. It interleaves CPU reads and writes into the remaining RAM slots through a four-phase req/ack handshake. It drives one synchronous RAM with a 1-cycle read latency.

## Interface
- ADDR_W, 16, address width for all ports
- DATA_W, 8, data width for all ports

- I_clock  in  1  system clock; all logic on its rising edge
- I_reset  in  1  asynchronous, active-low reset
- I_vid_rden  in  1  video fetch read strobe; level, held high for several clocks per fetch
- I_vid_addr  in  ADDR_W  video fetch address; stable while I_vid_rden is high
- O_vid_data  out  DATA_W  last video read result; held until the next video read completes
- I_cpu_req  in  1  CPU access request (four-phase)
- I_cpu_we  in  1  1 = write, 0 = read; qualified by I_cpu_req
- I_cpu_addr  in  ADDR_W  CPU address; stable while I_cpu_req is high
- I_cpu_wdata  in  DATA_W  CPU write data
- O_cpu_ack  out  1  access complete; high until I_cpu_req falls
- O_cpu_rdata  out  DATA_W  last CPU read result; unchanged by writes
- O_ram_addr  out  ADDR_W  RAM address
- O_ram_wren  out  1  RAM write enable
- O_ram_wdata  out  DATA_W  RAM write data
- I_ram_rdata  in  DATA_W  RAM read data; valid one clock after the address is registered

## Operation
- Video request detection:
  - vid_edge = I_vid_rden & ~rden_last. rden_last is I_vid_rden registered.
  - vid_pend is set on vid_edge when the edge cannot be issued in the same cycle.
  - vid_pend clears on issue. It is a single flag, so repeated edges while pending collapse into one request.
- State machine states: IDLE, VID_WAIT, CPU_WAIT.
- IDLE:
  - If vid_edge or vid_pend: O_ram_addr <= I_vid_addr, O_ram_wren <= 0, go to VID_WAIT.
  - Else if I_cpu_req and ~O_cpu_ack: O_ram_addr <= I_cpu_addr, O_ram_wdata <= I_cpu_wdata, O_ram_wren <= I_cpu_we, go to CPU_WAIT.
  - Else stay in IDLE with O_ram_wren <= 0.
- VID_WAIT: O_vid_data <= I_ram_rdata, go to IDLE.
- CPU_WAIT:
  - O_ram_wren <= 0.
  - If the access is a read: O_cpu_rdata <= I_ram_rdata.
  - O_cpu_ack <= 1, go to IDLE.
- Handshake:
  - O_cpu_ack clears on the first clock where I_cpu_req is sampled low.
  - No new CPU access is accepted while O_cpu_ack is high.
- Priority: video always wins. A simultaneous vid_edge and CPU request in IDLE issues the video read; the CPU request waits.
- A vid_edge arriving in VID_WAIT or CPU_WAIT sets vid_pend. It is issued on the next IDLE cycle, ahead of any CPU request.
- Address widths are passed through unchanged; no address arithmetic is performed.
- Reset (asynchronous, any state, including mid-access):
  - State returns to IDLE; vid_pend and rden_last clear.
  - All outputs go to 0: O_vid_data, O_cpu_ack, O_cpu_rdata, O_ram_addr, O_ram_wren, O_ram_wdata.
  - An in-flight access is abandoned: no ack, no data update.

## Timing
- Video latency (edge sampled at clock t):
  - Best case, IDLE at t: O_vid_data valid after edge t+2.
  - Worst case, CPU_WAIT at t: O_vid_data valid after edge t+3.
- The fetch stage samples data 8 clocks after raising I_vid_rden (2 pixel ticks at 4 clocks each), which leaves margin of ≥5 clocks.
- CPU latency: O_cpu_ack rises 2 clocks after acceptance in IDLE. If blocked by video, add 2 clocks per video read serviced first.
- CPU write: O_ram_wren is high for exactly one clock per accepted write.
- Throughput: at most one RAM access every 2 clocks. Video uses 2 reads per 8-pixel tile (2 of every 32 clocks), so the CPU cannot starve.
- O_vid_data and O_cpu_rdata change only on the VID_WAIT and CPU_WAIT transitions respectively.

## Test plan
- Reset, then pulse I_vid_rden high for 8 clocks with I_vid_addr=0x6005 and RAM[0x6005]=0xA7 -> O_ram_addr=0x6005 one clock after the edge; O_vid_data=0xA7 two clocks after the edge; exactly one RAM read.
- CPU write req, we=1, addr=0x5810, wdata=0x3C -> O_ram_wren high for one clock with addr 0x5810 and data 0x3C; ack after 2 clocks; ack drops one clock after req falls; readback req gives O_cpu_rdata=0x3C.
- CPU read and vid_edge in the same IDLE cycle -> video read issued first; O_vid_data updates at +2; CPU ack at +4.
- vid_edge one clock after a CPU access is accepted -> vid_pend set; video read issued at the CPU_WAIT->IDLE boundary; O_vid_data valid 3 clocks after the edge; CPU ack unaffected.
- CPU holds req high after ack -> no second access and O_ram_wren stays 0 until req drops and re-rises.
- Assert I_reset low during VID_WAIT -> all outputs 0 immediately; no ack; after release, the next vid_edge is serviced normally.
